// File: rtl/tetarto_meros.sv
// Scrolling 4-digit multiplexed 7-segment driver for the hex message "0123456789AbCdEF".
// Optional macro ANTIGHOST_EN blanks all anodes and segments for the first clock of each digit slot.
module tetarto_meros #(
  parameter int DIGIT_CYCLES = 16,
  parameter int SHIFT_CYCLES = 1024
) (
  input  logic reset,
  input  logic clk,
  output logic an3,
  output logic an2,
  output logic an1,
  output logic an0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic dp
);

  localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int SW = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_CYCLES - 1);

  logic [DW-1:0] div_cnt_reg;
  logic [1:0]    dig_reg;
  logic [SW-1:0] shift_cnt_reg;
  logic [3:0]    ptr_reg;

  logic [3:0] sym;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       blank;

  // The 4-bit add wraps naturally, so the window rolls from F back to 0.
  always_comb begin
    sym = ptr_reg + {2'b00, dig_reg};
    seg_next = 7'b1111111;
    case (sym)
      4'h0: seg_next = 7'b0000001;
      4'h1: seg_next = 7'b1001111;
      4'h2: seg_next = 7'b0010010;
      4'h3: seg_next = 7'b0000110;
      4'h4: seg_next = 7'b1001100;
      4'h5: seg_next = 7'b0100100;
      4'h6: seg_next = 7'b0100000;
      4'h7: seg_next = 7'b0001111;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0000100;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b1100000;
      4'hC: seg_next = 7'b0110001;
      4'hD: seg_next = 7'b1000010;
      4'hE: seg_next = 7'b0110000;
      default: seg_next = 7'b0111000;
    endcase
    an_next = ~(4'b1000 >> dig_reg);
`ifdef ANTIGHOST_EN
    blank = (div_cnt_reg == '0);
`else
    blank = 1'b0;
`endif
    if (blank) begin
      an_next  = 4'b1111;
      seg_next = 7'b1111111;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg   <= '0;
      dig_reg       <= 2'd0;
      shift_cnt_reg <= '0;
      ptr_reg       <= 4'd0;
      {an3, an2, an1, an0}     <= 4'b1111;
      {a, b, c, d, e, f, g}    <= 7'b1111111;
      dp                       <= 1'b1;
    end else begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg <= '0;
        dig_reg     <= dig_reg + 2'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + DW'(1);
      end
      // Scroll timing runs independently of digit multiplexing.
      if (shift_cnt_reg == SHIFT_LAST) begin
        shift_cnt_reg <= '0;
        ptr_reg       <= ptr_reg + 4'd1;
      end else begin
        shift_cnt_reg <= shift_cnt_reg + SW'(1);
      end
      {an3, an2, an1, an0}  <= an_next;
      {a, b, c, d, e, f, g} <= seg_next;
      dp                    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tetarto_meros.sv
// Scoreboard bench for tetarto_meros: random run lengths and mid-slot resets,
// expected outputs derived from the elapsed edge count since reset release.
module tb_tetarto_meros;

  localparam int DC = 4;
  localparam int SC = 64;
  localparam logic [11:0] BLANK = 12'hFFF;

  logic clk;
  logic reset;
  logic an3, an2, an1, an0, a, b, c, d, e, f, g, dp;

  tetarto_meros #(.DIGIT_CYCLES(DC), .SHIFT_CYCLES(SC)) dut (
    .reset(reset), .clk(clk),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0]  segtab [16];
  logic [11:0] expq [$];
  int          tests;
  int          fails;
  int          edge_cnt;

  // Output after the n-th edge since release reflects counters after n-1 edges.
  function automatic logic [11:0] model(input int n);
    int m, dg, pt, dv;
    logic [3:0] an;
    logic [3:0] sy;
    m  = n - 1;
    dv = m % DC;
    dg = (m / DC) % 4;
    pt = (m / SC) % 16;
    sy = 4'((pt + dg) % 16);
    an = 4'b1111;
    an[3 - dg] = 1'b0;
`ifdef ANTIGHOST_EN
    if (dv == 0) return BLANK;
`else
    if (dv < 0) return BLANK;
`endif
    return {an, segtab[sy], 1'b1};
  endfunction

  // action: 0 = none, 1 = assert reset mid-slot, 2 = release reset
  task automatic step(input int action);
    @(posedge clk);
    if (!reset) edge_cnt++;
    #2;
    if (action == 1) begin
      reset = 1'b1;
      edge_cnt = 0;
    end else if (action == 2) begin
      reset = 1'b0;
    end
    #1;
    if (reset || edge_cnt == 0) expq.push_back(BLANK);
    else expq.push_back(model(edge_cnt));
  endtask

  always @(negedge clk) begin
    logic [11:0] got, want;
    if (expq.size() > 0) begin
      want = expq.pop_front();
      got  = {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL outputs t=%0t edge=%0d reset=%b got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 $time, edge_cnt, reset, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
      end
    end
  end

  initial begin
    int n, h;
    tests = 0;
    fails = 0;
    edge_cnt = 0;
    reset = 1'b1;
    segtab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    step(0);
    step(2);
    $display("[TB] phase 0: full scroll run of 1100 cycles");
    for (int i = 0; i < 1100; i++) step(0);
    for (int k = 1; k <= 40; k++) begin
      n = $urandom_range(1, 300);
      h = $urandom_range(0, 2);
      $display("[TB] phase %0d: mid-slot reset after %0d cycles, held %0d extra cycles", k, n, h);
      step(1);
      for (int i = 0; i < h; i++) step(0);
      step(2);
      for (int i = 0; i < n; i++) step(0);
    end
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
